// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants and state encoding for the parking gate keypad path
package parking_pkg;

  localparam int PIN_W = 8;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  // One-hot so the encoding lines up with the gate controller's state register.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_COLLECT = 3'b010,
    ST_SUBMIT  = 3'b100
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - idle-cycle down-counter that flags an expired entry window
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  // Expiry is combinational so the owner can act on the same edge as the last idle cycle.
  assign expired = run && !restart && (cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= LOAD;
    end else if (restart) begin
      cnt <= LOAD;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pin_entry.sv
// rtl/pin_entry.sv - keypad digit collector that assembles and submits a binary PIN
module pin_entry
  import parking_pkg::*;
#(
  parameter int MAX_DIGITS     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [PIN_W-1:0] pin,
  output logic             pin_valid,
  output logic [1:0]       digit_cnt,
  output logic             busy,
  output logic             entry_err
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  entry_state_t     state;
  logic [PIN_W-1:0] acc;
  logic [PIN_W-1:0] acc_next;
  logic             timer_restart;
  logic             timer_run;
  logic             timer_expired;

  // acc*10 + digit using shifts; acc never exceeds 99 so nothing is lost.
  assign acc_next = {acc[4:0], 3'b000} + {acc[6:0], 1'b0} + {4'b0000, key_code};

  assign timer_restart = (state != ST_COLLECT) || key_valid;
  assign timer_run     = (state == ST_COLLECT) && !key_valid;

  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .restart(timer_restart),
    .run    (timer_run),
    .expired(timer_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      pin       <= '0;
      pin_valid <= 1'b0;
      digit_cnt <= 2'd0;
      busy      <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      pin_valid <= 1'b0;
      entry_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && key_valid) begin
            if (is_digit(key_code)) begin
              acc       <= {4'b0000, key_code};
              digit_cnt <= 2'd1;
              busy      <= 1'b1;
              state     <= ST_COLLECT;
            end else if (key_code != KEY_CLEAR && key_code != KEY_ENTER) begin
              entry_err <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (!enable) begin
            acc       <= '0;
            digit_cnt <= 2'd0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (key_valid) begin
            if (is_digit(key_code)) begin
              if (digit_cnt < MAX_CNT) begin
                acc       <= acc_next;
                digit_cnt <= digit_cnt + 2'd1;
              end else begin
                entry_err <= 1'b1;
                acc       <= '0;
                digit_cnt <= 2'd0;
                busy      <= 1'b0;
                state     <= ST_IDLE;
              end
            end else if (key_code == KEY_ENTER) begin
              pin       <= acc;
              pin_valid <= 1'b1;
              acc       <= '0;
              digit_cnt <= 2'd0;
              busy      <= 1'b0;
              state     <= ST_SUBMIT;
            end else if (key_code == KEY_CLEAR) begin
              acc       <= '0;
              digit_cnt <= 2'd0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              entry_err <= 1'b1;
            end
          end else if (timer_expired) begin
            entry_err <= 1'b1;
            acc       <= '0;
            digit_cnt <= 2'd0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_SUBMIT: begin
          state <= ST_IDLE;
        end
        default: begin
          acc       <= '0;
          digit_cnt <= 2'd0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry.sv
// tb/tb_pin_entry.sv - directed self-checking bench for pin_entry
`define CHK(tag, obs, exp) \
  begin \
    n_assert++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); \
    end \
  end

module tb_pin_entry;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [7:0] pin;
  logic       pin_valid;
  logic [1:0] digit_cnt;
  logic       busy;
  logic       entry_err;

  int n_assert = 0;
  int n_fail   = 0;
  int err_seen;

  always #5 clock = ~clock;

  pin_entry #(
    .MAX_DIGITS    (2),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .key_valid(key_valid),
    .key_code (key_code),
    .pin      (pin),
    .pin_valid(pin_valid),
    .digit_cnt(digit_cnt),
    .busy     (busy),
    .entry_err(entry_err)
  );

  task automatic step(input logic v, input logic [3:0] c);
    @(negedge clock);
    key_valid = v;
    key_code  = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    `CHK("rst_pin", pin, 8'd0)
    `CHK("rst_pin_valid", pin_valid, 1'b0)
    `CHK("rst_digit_cnt", digit_cnt, 2'd0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_entry_err", entry_err, 1'b0)
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b1;

    // 7, 2, ENTER back to back
    step(1'b1, 4'd7);
    `CHK("t1_cnt1", digit_cnt, 2'd1)
    `CHK("t1_busy", busy, 1'b1)
    step(1'b1, 4'd2);
    `CHK("t1_cnt2", digit_cnt, 2'd2)
    `CHK("t1_err_a", entry_err, 1'b0)
    step(1'b1, 4'hB);
    `CHK("t1_pin", pin, 8'd72)
    `CHK("t1_pv", pin_valid, 1'b1)
    `CHK("t1_cnt0", digit_cnt, 2'd0)
    `CHK("t1_busy0", busy, 1'b0)
    `CHK("t1_err_b", entry_err, 1'b0)
    step(1'b0, 4'd0);
    `CHK("t1_pv_end", pin_valid, 1'b0)
    `CHK("t1_pin_hold", pin, 8'd72)

    // 4, CLEAR, 9, ENTER
    step(1'b1, 4'd4);
    `CHK("t2_cnt1", digit_cnt, 2'd1)
    step(1'b1, 4'hA);
    `CHK("t2_clr_cnt", digit_cnt, 2'd0)
    `CHK("t2_clr_busy", busy, 1'b0)
    `CHK("t2_clr_err", entry_err, 1'b0)
    step(1'b1, 4'd9);
    step(1'b1, 4'hB);
    `CHK("t2_pin", pin, 8'd9)
    `CHK("t2_pv", pin_valid, 1'b1)
    step(1'b0, 4'd0);
    `CHK("t2_pv_end", pin_valid, 1'b0)

    // 1, 2, 3 overflows on the third digit
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    `CHK("t3_cnt2", digit_cnt, 2'd2)
    step(1'b1, 4'd3);
    `CHK("t3_err", entry_err, 1'b1)
    `CHK("t3_cnt0", digit_cnt, 2'd0)
    `CHK("t3_busy0", busy, 1'b0)
    `CHK("t3_pin", pin, 8'd9)
    `CHK("t3_pv", pin_valid, 1'b0)
    step(1'b0, 4'd0);
    `CHK("t3_err_end", entry_err, 1'b0)

    // Invalid code in IDLE and in COLLECT
    step(1'b1, 4'hE);
    `CHK("inv_idle_err", entry_err, 1'b1)
    `CHK("inv_idle_cnt", digit_cnt, 2'd0)
    step(1'b1, 4'd6);
    `CHK("inv_idle_err_end", entry_err, 1'b0)
    step(1'b1, 4'hF);
    `CHK("inv_col_err", entry_err, 1'b1)
    `CHK("inv_col_cnt", digit_cnt, 2'd1)
    `CHK("inv_col_busy", busy, 1'b1)
    step(1'b1, 4'd3);
    `CHK("inv_col_cnt2", digit_cnt, 2'd2)
    step(1'b1, 4'hB);
    `CHK("inv_col_pin", pin, 8'd63)
    `CHK("inv_col_pv", pin_valid, 1'b1)
    step(1'b0, 4'd0);

    // 5, then timeout after exactly 1000 idle cycles
    step(1'b1, 4'd5);
    `CHK("t4_busy", busy, 1'b1)
    err_seen = 0;
    for (int i = 0; i < 999; i++) begin
      step(1'b0, 4'd0);
      if (entry_err) err_seen++;
    end
    `CHK("t4_early_err", err_seen, 0)
    `CHK("t4_busy_999", busy, 1'b1)
    step(1'b0, 4'd0);
    `CHK("t4_to_err", entry_err, 1'b1)
    `CHK("t4_to_busy", busy, 1'b0)
    `CHK("t4_to_cnt", digit_cnt, 2'd0)
    step(1'b0, 4'd0);
    `CHK("t4_err_end", entry_err, 1'b0)
    step(1'b1, 4'hB);
    `CHK("t4_enter_pv", pin_valid, 1'b0)
    `CHK("t4_enter_pin", pin, 8'd63)
    step(1'b0, 4'd0);

    // 7, enable low one cycle, 2, ENTER
    step(1'b1, 4'd7);
    `CHK("t5_cnt1", digit_cnt, 2'd1)
    @(negedge clock);
    key_valid = 1'b0;
    enable    = 1'b0;
    @(posedge clock);
    #1;
    `CHK("t5_dis_busy", busy, 1'b0)
    `CHK("t5_dis_cnt", digit_cnt, 2'd0)
    `CHK("t5_dis_err", entry_err, 1'b0)
    enable = 1'b1;
    step(1'b1, 4'd2);
    step(1'b1, 4'hB);
    `CHK("t5_pin", pin, 8'd2)
    `CHK("t5_pv", pin_valid, 1'b1)
    `CHK("t5_err", entry_err, 1'b0)
    step(1'b0, 4'd0);

    // 8, async reset mid-cycle, then ENTER
    step(1'b1, 4'd8);
    `CHK("t6_busy", busy, 1'b1)
    @(negedge clock);
    key_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    `CHK("t6_rst_pin", pin, 8'd0)
    `CHK("t6_rst_busy", busy, 1'b0)
    `CHK("t6_rst_cnt", digit_cnt, 2'd0)
    `CHK("t6_rst_pv", pin_valid, 1'b0)
    `CHK("t6_rst_err", entry_err, 1'b0)
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 4'hB);
    `CHK("t6_enter_pv", pin_valid, 1'b0)
    `CHK("t6_enter_pin", pin, 8'd0)
    step(1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
